// File: rtl/seg7_hex_scanner.sv
// rtl/seg7_hex_scanner.sv - 8-digit hex seven-segment scanner with frame-synchronous word update
// Shows a 32-bit word as 8 hex digits; loaded words are shadowed until the end of digit 7's dwell.
module seg7_hex_scanner #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] inputData,
  input  logic        load,
  input  logic        blankLZ,
  input  logic [7:0]  dpMask,
  output logic [7:0]  tubeSelect,
  output logic [7:0]  tubeChar,
  output logic        frameDone,
  output logic        updatePending
);

  localparam int unsigned      CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       OFF     = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       char_q, char_d;

  logic             dwell_end;
  logic             boundary;
  logic [31:0]      upper;
  logic             blank;
  logic [7:0]       sel_n;
  logic [7:0]       seg_n;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 8'hC0;
      4'h1:    hex_seg = 8'hF9;
      4'h2:    hex_seg = 8'hA4;
      4'h3:    hex_seg = 8'hB0;
      4'h4:    hex_seg = 8'h99;
      4'h5:    hex_seg = 8'h92;
      4'h6:    hex_seg = 8'h82;
      4'h7:    hex_seg = 8'hF8;
      4'h8:    hex_seg = 8'h80;
      4'h9:    hex_seg = 8'h90;
      4'hA:    hex_seg = 8'h88;
      4'hB:    hex_seg = 8'h83;
      4'hC:    hex_seg = 8'hC6;
      4'hD:    hex_seg = 8'hA1;
      4'hE:    hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    dwell_end    = (cnt_q == CNT_MAX);
    boundary     = dwell_end && (idx_q == 3'd7);
    frame_done_d = boundary;

    if (dwell_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end

    // A load landing exactly on the boundary bypasses the shadow and wins.
    if (boundary) begin
      if (load) begin
        disp_d    = inputData;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = inputData;
      pending_d = 1'b1;
    end

    // A digit is a leading zero when it and every nibble above it are zero.
    upper = disp_q >> {idx_q, 2'b00};
    blank = blankLZ && (idx_q != 3'd0) && (upper == 32'd0);
    seg_n = blank ? 8'hFF : hex_seg(upper[3:0]);
    if (dpMask[idx_q]) begin
      seg_n[7] = 1'b0;
    end
    sel_n = ~(8'b1 << idx_q);

    sel_d  = ACTIVE_LOW ? sel_n : ~sel_n;
    char_d = ACTIVE_LOW ? seg_n : ~seg_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 32'd0;
      disp_q       <= 32'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sel_q        <= OFF;
      char_q       <= OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      sel_q        <= sel_d;
      char_q       <= char_d;
    end
  end

  assign tubeSelect    = sel_q;
  assign tubeChar      = char_q;
  assign frameDone     = frame_done_q;
  assign updatePending = pending_q;

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// tb/tb_seg7_hex_scanner.sv - directed vector bench for seg7_hex_scanner (SCAN_DIV=4, ACTIVE_LOW=1)
module tb_seg7_hex_scanner;

  localparam int unsigned SCAN_DIV = 4;

  logic        CLK;
  logic        RST;
  logic [31:0] inputData;
  logic        load;
  logic        blankLZ;
  logic [7:0]  dpMask;
  logic [7:0]  tubeSelect;
  logic [7:0]  tubeChar;
  logic        frameDone;
  logic        updatePending;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] word;
    logic        blz;
    logic [7:0]  dp;
    logic [63:0] exp;   // {digit7 .. digit0} tubeChar values
  } vec_t;

  vec_t vecs [9];

  seg7_hex_scanner #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .inputData     (inputData),
    .load          (load),
    .blankLZ       (blankLZ),
    .dpMask        (dpMask),
    .tubeSelect    (tubeSelect),
    .tubeChar      (tubeChar),
    .frameDone     (frameDone),
    .updatePending (updatePending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fd(input string name);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (frameDone !== 1'b1 && k < 40);
    check(name, {31'd0, frameDone}, 32'd1);
  endtask

  // Called in the frameDone cycle; checks every digit of the following frame.
  task automatic sample_frame(input logic [63:0] exp, input string tag);
    logic [7:0] exp_sel;
    tick(1);
    check({tag, "_fd_pulse"}, {31'd0, frameDone}, 32'd0);
    for (int d = 0; d < 8; d++) begin
      if (d != 0) tick(4);
      exp_sel = ~(8'b1 << d);
      check($sformatf("%s_sel%0d", tag, d), {24'd0, tubeSelect}, {24'd0, exp_sel});
      check($sformatf("%s_char%0d", tag, d), {24'd0, tubeChar}, {24'd0, exp[8*d +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int k;

    vecs[0] = '{32'h000000A0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_88C0};
    vecs[1] = '{32'h00000000, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[2] = '{32'hFFFFFFFF, 1'b0, 8'h04, 64'h8E8E_8E8E_8E0E_8E8E};
    vecs[3] = '{32'h00000000, 1'b1, 8'h04, 64'hFFFF_FFFF_FF7F_FFC0};
    vecs[4] = '{32'h89ABCDEF, 1'b0, 8'h81, 64'h0090_8883_C6A1_860E};
    vecs[5] = '{32'h00F00000, 1'b1, 8'h00, 64'hFFFF_8EC0_C0C0_C0C0};
    vecs[6] = '{32'h10000000, 1'b1, 8'h00, 64'hF9C0_C0C0_C0C0_C0C0};
    vecs[7] = '{32'h12345678, 1'b0, 8'h00, 64'hF9A4_B099_9282_F880};
    vecs[8] = '{32'h01234567, 1'b1, 8'h80, 64'h7FF9_A4B0_9992_82F8};

    RST = 1'b1; load = 1'b0; inputData = 32'd0; blankLZ = 1'b0; dpMask = 8'h00;
    tick(2);
    RST = 1'b0;

    // Reset state, then idle scan of an all-zero word
    check("rst_sel", {24'd0, tubeSelect}, 32'hFF);
    check("rst_char", {24'd0, tubeChar}, 32'hFF);
    check("rst_pend", {31'd0, updatePending}, 32'd0);
    check("rst_fd", {31'd0, frameDone}, 32'd0);
    sample_frame(64'hC0C0_C0C0_C0C0_C0C0, "idle");
    tick(2);
    check("idle_fd_before", {31'd0, frameDone}, 32'd0);
    tick(1);
    check("idle_fd_first", {31'd0, frameDone}, 32'd1);
    tick(32);
    check("idle_fd_period", {31'd0, frameDone}, 32'd1);

    // Load at idx=3: nothing changes until the frame boundary
    tick(13);
    inputData = 32'h12345678; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("mid_pend_set", {31'd0, updatePending}, 32'd1);
    bad = 0; k = 0;
    while (frameDone !== 1'b1 && k < 40) begin
      if (tubeChar !== 8'hC0 || updatePending !== 1'b1) bad++;
      tick(1);
      k++;
    end
    check("mid_fd_seen", {31'd0, frameDone}, 32'd1);
    check("mid_no_tear", bad, 32'd0);
    check("mid_pend_clr", {31'd0, updatePending}, 32'd0);
    sample_frame(64'hF9A4_B099_9282_F880, "mid");

    for (int v = 0; v < 9; v++) begin
      blankLZ = vecs[v].blz; dpMask = vecs[v].dp;
      inputData = vecs[v].word; load = 1'b1;
      tick(1);
      load = 1'b0;
      check($sformatf("vec%0d_pend_set", v), {31'd0, updatePending}, 32'd1);
      wait_fd($sformatf("vec%0d_fd", v));
      check($sformatf("vec%0d_pend_clr", v), {31'd0, updatePending}, 32'd0);
      sample_frame(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Mid-frame load, then a load exactly on the boundary: the boundary load wins
    blankLZ = 1'b0; dpMask = 8'h00;
    inputData = 32'hAAAAAAAA; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("race_pend_set", {31'd0, updatePending}, 32'd1);
    tick(1);
    check("race_pre_b", {31'd0, frameDone}, 32'd0);
    inputData = 32'h55555555; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("race_fd", {31'd0, frameDone}, 32'd1);
    check("race_pend_clr", {31'd0, updatePending}, 32'd0);
    sample_frame(64'h9292_9292_9292_9292, "race");

    // Two loads within one frame: the last one wins
    wait_fd("multi_fd0");
    inputData = 32'h00000001; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(5);
    inputData = 32'h00000002; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("multi_pend_set", {31'd0, updatePending}, 32'd1);
    wait_fd("multi_fd1");
    check("multi_pend_clr", {31'd0, updatePending}, 32'd0);
    sample_frame(64'hC0C0_C0C0_C0C0_C0A4, "multi");

    // Reset at idx=5 with a word pending
    wait_fd("rst2_fd0");
    inputData = 32'hDEADBEEF; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("rst2_pend_set", {31'd0, updatePending}, 32'd1);
    tick(19);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("rst2_sel", {24'd0, tubeSelect}, 32'hFF);
    check("rst2_char", {24'd0, tubeChar}, 32'hFF);
    check("rst2_pend", {31'd0, updatePending}, 32'd0);
    check("rst2_fd", {31'd0, frameDone}, 32'd0);
    sample_frame(64'hC0C0_C0C0_C0C0_C0C0, "rst2_a");
    wait_fd("rst2_fd1");
    check("rst2_pend_after", {31'd0, updatePending}, 32'd0);
    sample_frame(64'hC0C0_C0C0_C0C0_C0C0, "rst2_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
